// File: rtl/spi_ram_burst.sv
// Command-decoded single-port RAM sitting behind the SPI slave shift logic.
// Supports burst auto-increment, a tx_valid/tx_ready read-data handshake and a sticky overrun flag.
module spi_ram_burst #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int AUTO_INC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [DATA_W+1:0] din,
  input  logic              tx_ready,
  input  logic              clr_ovf,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid,
  output logic              ovf
);

  localparam logic [1:0] CMD_SET_WR = 2'b00;
  localparam logic [1:0] CMD_WRITE  = 2'b01;
  localparam logic [1:0] CMD_SET_RD = 2'b10;
  localparam logic [1:0] CMD_READ   = 2'b11;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;

  logic [1:0]        cmd;
  logic [DATA_W-1:0] payload;
  logic [ADDR_W-1:0] addr;
  logic              wr_en;
  logic              rd_req;
  logic              rd_accept;
  logic              rd_drop;

  assign cmd     = din[DATA_W+1:DATA_W];
  assign payload = din[DATA_W-1:0];
  assign addr    = payload[ADDR_W-1:0];
  assign wr_en   = rx_valid && (cmd == CMD_WRITE);
  assign rd_req  = rx_valid && (cmd == CMD_READ);

  // Handshake: dout/tx_valid hold until a cycle with tx_valid=1 and tx_ready=1.
  // A read is taken when the output slot is empty or being emptied this cycle;
  // otherwise it is dropped and flagged as an overrun.
  assign rd_accept = rd_req && (!tx_valid || tx_ready);
  assign rd_drop   = rd_req && tx_valid && !tx_ready;

  // Storage is never reset; writes are suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      mem[wr_ptr] <= payload;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      dout     <= '0;
      tx_valid <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      if (rx_valid && (cmd == CMD_SET_WR)) begin
        wr_ptr <= addr;
      end else if (wr_en && (AUTO_INC != 0)) begin
        wr_ptr <= wr_ptr + 1'b1;
      end

      if (rx_valid && (cmd == CMD_SET_RD)) begin
        rd_ptr <= addr;
      end else if (rd_accept && (AUTO_INC != 0)) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      if (rd_accept) begin
        dout     <= mem[rd_ptr];
        tx_valid <= 1'b1;
      end else if (tx_valid && tx_ready) begin
        tx_valid <= 1'b0;
      end

      // Set wins over a simultaneous clear.
      if (rd_drop) begin
        ovf <= 1'b1;
      end else if (clr_ovf) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_ram_burst.sv
// Directed bench for spi_ram_burst: an 8/8 auto-increment instance and a 16/4 hold-pointer instance.
// Reads push expected words into queues; monitors pop and compare on every accepted transfer.
module tb_spi_ram_burst;

  logic clk;
  logic rst_n;

  logic        rx_valid0, tx_ready0, clr_ovf0;
  logic [9:0]  din0;
  logic [7:0]  dout0;
  logic        tx_valid0, ovf0;

  logic        rx_valid1, tx_ready1, clr_ovf1;
  logic [17:0] din1;
  logic [15:0] dout1;
  logic        tx_valid1, ovf1;

  logic [7:0]  exp_q0[$];
  logic [15:0] exp_q1[$];

  int errors = 0;
  int checks = 0;

  spi_ram_burst #(.DATA_W(8), .ADDR_W(8), .AUTO_INC(1)) u0 (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid0), .din(din0),
    .tx_ready(tx_ready0), .clr_ovf(clr_ovf0),
    .dout(dout0), .tx_valid(tx_valid0), .ovf(ovf0)
  );

  spi_ram_burst #(.DATA_W(16), .ADDR_W(4), .AUTO_INC(0)) u1 (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid1), .din(din1),
    .tx_ready(tx_ready1), .clr_ovf(clr_ovf1),
    .dout(dout1), .tx_valid(tx_valid1), .ovf(ovf1)
  );

  // clock / reset / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // drivers: called at posedge+1, return at the next posedge+1
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send0(input logic [1:0] c, input logic [7:0] p);
    rx_valid0 = 1'b1;
    din0      = {c, p};
    step(1);
    rx_valid0 = 1'b0;
  endtask

  task automatic send1(input logic [1:0] c, input logic [15:0] p);
    rx_valid1 = 1'b1;
    din1      = {c, p};
    step(1);
    rx_valid1 = 1'b0;
  endtask

  // scoreboard monitors
  always @(negedge clk) begin
    if (rst_n && tx_valid0 && tx_ready0) begin
      if (exp_q0.size() == 0) begin
        chk("u0_unexpected_word", {24'h0, dout0}, 32'hFFFF_FFFF);
      end else begin
        chk("u0_dout", {24'h0, dout0}, {24'h0, exp_q0.pop_front()});
      end
    end
    if (rst_n && tx_valid1 && tx_ready1) begin
      if (exp_q1.size() == 0) begin
        chk("u1_unexpected_word", {16'h0, dout1}, 32'hFFFF_FFFF);
      end else begin
        chk("u1_dout", {16'h0, dout1}, {16'h0, exp_q1.pop_front()});
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    rx_valid0 = 1'b0; din0 = '0; tx_ready0 = 1'b0; clr_ovf0 = 1'b0;
    rx_valid1 = 1'b0; din1 = '0; tx_ready1 = 1'b0; clr_ovf1 = 1'b0;
    step(3);
    rst_n = 1'b1;
    step(2);

    chk("rst_dout0", {24'h0, dout0}, 32'h0);
    chk("rst_tx_valid0", {31'h0, tx_valid0}, 32'h0);
    chk("rst_ovf0", {31'h0, ovf0}, 32'h0);
    chk("rst_dout1", {16'h0, dout1}, 32'h0);
    chk("rst_tx_valid1", {31'h0, tx_valid1}, 32'h0);
    chk("rst_ovf1", {31'h0, ovf1}, 32'h0);

    // burst write then back-to-back burst read
    tx_ready0 = 1'b1;
    send0(2'b00, 8'h10);
    send0(2'b01, 8'hA1);
    send0(2'b01, 8'hB2);
    send0(2'b01, 8'hC3);
    send0(2'b10, 8'h10);
    exp_q0.push_back(8'hA1); send0(2'b11, 8'h00);
    exp_q0.push_back(8'hB2); send0(2'b11, 8'h00);
    exp_q0.push_back(8'hC3); send0(2'b11, 8'h00);
    step(3);

    // pointer wrap 0xFF -> 0x00
    send0(2'b00, 8'hFF);
    send0(2'b01, 8'h55);
    send0(2'b01, 8'h66);
    send0(2'b10, 8'hFF);
    exp_q0.push_back(8'h55); send0(2'b11, 8'h00);
    exp_q0.push_back(8'h66); send0(2'b11, 8'h00);
    step(3);

    // backpressure and overrun
    tx_ready0 = 1'b0;
    send0(2'b10, 8'h10);
    exp_q0.push_back(8'hA1); send0(2'b11, 8'h00);
    chk("bp_tx_valid", {31'h0, tx_valid0}, 32'h1);
    chk("bp_dout_held", {24'h0, dout0}, 32'hA1);
    send0(2'b11, 8'h00);
    chk("bp_ovf_set", {31'h0, ovf0}, 32'h1);
    chk("bp_dout_after_drop", {24'h0, dout0}, 32'hA1);
    chk("bp_tx_valid_after_drop", {31'h0, tx_valid0}, 32'h1);
    tx_ready0 = 1'b1;
    step(1);
    chk("bp_tx_valid_cleared", {31'h0, tx_valid0}, 32'h0);
    exp_q0.push_back(8'hB2); send0(2'b11, 8'h00);
    step(2);
    chk("bp_ovf_sticky", {31'h0, ovf0}, 32'h1);
    clr_ovf0 = 1'b1;
    step(1);
    clr_ovf0 = 1'b0;
    chk("bp_ovf_cleared", {31'h0, ovf0}, 32'h0);

    // overrun and clr_ovf in the same cycle: set wins
    tx_ready0 = 1'b0;
    send0(2'b10, 8'h10);
    exp_q0.push_back(8'hA1); send0(2'b11, 8'h00);
    clr_ovf0 = 1'b1;
    send0(2'b11, 8'h00);
    clr_ovf0 = 1'b0;
    chk("sim_ovf_set_wins", {31'h0, ovf0}, 32'h1);
    tx_ready0 = 1'b1;
    step(2);
    clr_ovf0 = 1'b1;
    step(1);
    clr_ovf0 = 1'b0;

    // write then immediate read of the same address
    send0(2'b10, 8'h30);
    send0(2'b00, 8'h30);
    send0(2'b01, 8'h77);
    exp_q0.push_back(8'h77); send0(2'b11, 8'h00);
    step(3);

    // reset while a word is pending
    tx_ready0 = 1'b0;
    send0(2'b10, 8'h10);
    send0(2'b11, 8'h00);
    send0(2'b11, 8'h00);
    chk("mid_tx_valid_before_rst", {31'h0, tx_valid0}, 32'h1);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    chk("mid_rst_tx_valid", {31'h0, tx_valid0}, 32'h0);
    chk("mid_rst_ovf", {31'h0, ovf0}, 32'h0);
    chk("mid_rst_dout", {24'h0, dout0}, 32'h0);
    step(1);

    // 16-bit data, 4-bit address, pointer holds
    tx_ready1 = 1'b1;
    send1(2'b00, 16'h00F3);
    send1(2'b01, 16'hBEEF);
    send1(2'b01, 16'h1234);
    send1(2'b10, 16'h0003);
    exp_q1.push_back(16'h1234); send1(2'b11, 16'h0000);
    exp_q1.push_back(16'h1234); send1(2'b11, 16'h0000);
    step(3);

    chk("u0_queue_drained", exp_q0.size(), 32'h0);
    chk("u1_queue_drained", exp_q1.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_ram_burst.md
Name: spi_ram_burst

Overview:
- Parametrised command-decoded single-port RAM behind the SPI slave shift logic.
- Successor to the fixed 8-bit / 256-entry SPI RAM, adding:
  - configurable data and address width;
  - optional address auto-increment for burst writes and reads;
  - a tx_valid/tx_ready output handshake;
  - a sticky overrun flag.
- Receives {cmd[1:0], payload} words from the SPI slave and returns read data to it for shifting out on MISO.

Parameters:
- DATA_W, 8, data word width; payload width of din.
- ADDR_W, 8, address width; must satisfy ADDR_W <= DATA_W; memory depth = 2**ADDR_W.
- AUTO_INC, 1, 1 = address pointer increments after each data write/read; 0 = pointer holds.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- rx_valid  input  1  din holds a valid command word this cycle.
- din  input  DATA_W+2  [DATA_W+1:DATA_W] = cmd, [DATA_W-1:0] = payload.
- tx_ready  input  1  consumer accepts dout this cycle when tx_valid=1.
- clr_ovf  input  1  clears ovf (synchronous, single cycle).
- dout  output  DATA_W  read data, registered.
- tx_valid  output  1  dout valid; held until accepted.
- ovf  output  1  sticky: a read command was dropped because dout was still pending.

Behaviour:
- Reset (rst_n=0 at clk edge):
  - dout=0, tx_valid=0, ovf=0, wr_ptr=0, rd_ptr=0.
  - MEM contents are not reset.
  - Reset has priority over every other input, including mid-burst and mid-handshake; a pending tx_valid is dropped.
- Commands are decoded only when rx_valid=1, at most one per cycle. Address = payload[ADDR_W-1:0]; upper payload bits are ignored.
  - cmd 00 (set write addr): wr_ptr <= addr.
  - cmd 01 (write data): MEM[wr_ptr] <= payload; if AUTO_INC, wr_ptr <= wr_ptr+1.
  - cmd 10 (set read addr): rd_ptr <= addr.
  - cmd 11 (read data): reads MEM[rd_ptr], never wr_ptr. If accepted:
    - dout <= MEM[rd_ptr], tx_valid <= 1;
    - if AUTO_INC, rd_ptr <= rd_ptr+1.
- Read latency: dout and tx_valid are valid on the clock edge following the accepted cmd 11 cycle (1 cycle).
- Handshake:
  - tx_valid stays 1 and dout stays stable until a cycle with tx_valid=1 and tx_ready=1.
  - tx_valid clears at that edge unless a new read is accepted in the same cycle.
  - A read is accepted iff tx_valid=0, or tx_ready=1 in the same cycle (back-to-back reads sustain one word per cycle).
- Overrun:
  - cmd 11 arriving while tx_valid=1 and tx_ready=0 is dropped: no dout change, no rd_ptr change, ovf <= 1.
  - clr_ovf=1 clears ovf. If an overrun and clr_ovf occur in the same cycle, set wins (ovf=1).
- Pointer wrap: wr_ptr and rd_ptr are ADDR_W-bit modulo counters; 2**ADDR_W-1 increments to 0 with no flag.
- Write-then-read of the same address in consecutive cycles returns the newly written data (no bypass needed; the write completes first).
- rx_valid=0: no state change except the handshake clearing tx_valid.
- tx_ready while tx_valid=0 is ignored.
- The target RAM inference is a flat reg array, single write port, single registered read port.

Test Plan:
- Reset, then idle -> dout=0, tx_valid=0, ovf=0. Assert rst_n=0 while tx_valid=1 -> tx_valid=0 on the next edge.
- Defaults, tx_ready=1. Write burst 00:0x10; 01:0xA1, 0xB2, 0xC3. Then 10:0x10 and three 11 commands back-to-back -> dout=0xA1, 0xB2, 0xC3 on consecutive cycles, tx_valid=1 for 3 cycles.
- Wrap, AUTO_INC=1. Write 0x55 at addr 0xFF followed by 0x66 (lands at 0x00). Read from 0xFF twice -> 0x55 then 0x66.
- Backpressure, tx_ready=0. Read addr 0x10 -> tx_valid=1, dout=0xA1 held. Second cmd 11 -> dropped, ovf=1, dout still 0xA1. tx_ready=1 -> accepted. Next read returns 0xB2 (rd_ptr did not advance on the drop). clr_ovf -> ovf=0.
- AUTO_INC=0, DATA_W=16, ADDR_W=4. Write 00:0x00F3 (addr=3), then 01:0xBEEF, then 01:0x1234. Read 10:3 + 11 -> dout=0x1234; repeat 11 -> 0x1234 again.
- Simultaneous: clr_ovf=1 in the same cycle as an overrun -> ovf=1. cmd 01 then immediately 11 on the same address -> new data returned.
